instr_fetch_unit: RTL

- Front-end stage of the LEGv8 single-cycle processor.
- Owns the PC and fetches 32-bit instructions from instruction memory over a request/acknowledge handshake.
- Presents each instruction to the decode/control stage with its opcode field `instr[31:21]` broken out.
- Applies the redirect computed by the datapath (conditional or unconditional branch) when an instruction retires.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_perf_counters.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding and instruction-field constants for the
//               LEGv8 instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_VALID = 2'd2;

  localparam int INSTR_BYTES = 4;
  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 21;

endpackage

`default_nettype wire

// File: rtl/fetch_perf_counters.sv
// ============================================================================
// Module      : fetch_perf_counters
// Description : Two saturating event counters (retired instructions, fetch
//               stall cycles) with independent increment enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_perf_counters #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_inc,
  input  logic              stall_inc,
  output logic [PERF_W-1:0] instr_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [PERF_W-1:0] c_max = '1;

  logic [PERF_W-1:0] r_instr_cnt;
  logic [PERF_W-1:0] r_stall_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (instr_inc && (r_instr_cnt != c_max))
        r_instr_cnt <= r_instr_cnt + 1'b1;
      if (stall_inc && (r_stall_cnt != c_max))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : LEGv8 fetch stage: owns the PC, fetches over a req/ack
//               handshake and applies datapath redirects on retire.
//               Optional counters enabled by defining FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int PERF_W  = 32
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [ADDR_W-1:0]  startPC,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [10:0]        opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_instr_cnt,
  output logic [PERF_W-1:0]  perf_stall_cnt
`endif
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [INSTR_W-1:0] r_instr;

  // Low address bits are forced to zero, so they are never consumed.
  logic w_unused;
  assign w_unused = &{1'b0, startPC[1:0], branch_target[1:0]};

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_instr_pc <= '0;
      r_instr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc    <= {startPC[ADDR_W-1:2], 2'b00};
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_state    <= ST_VALID;
          end
        end
        ST_VALID: begin
          // Redirect inputs only matter on the retire cycle.
          if (instr_ready) begin
            r_pc    <= branch_taken ? {branch_target[ADDR_W-1:2], 2'b00}
                                    : r_pc + ADDR_W'(INSTR_BYTES);
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_VALID);
  assign instr       = r_instr;
  assign opcode      = r_instr[OPC_HI:OPC_LO];
  assign instr_pc    = r_instr_pc;

`ifdef FETCH_PERF_EN
  logic w_retire;
  logic w_stall;
  assign w_retire = (r_state == ST_VALID) & instr_ready;
  assign w_stall  = (r_state == ST_FETCH) & ~imem_ack;

  fetch_perf_counters #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk       (CLK),
    .rst_n     (Reset_L),
    .instr_inc (w_retire),
    .stall_inc (w_stall),
    .instr_cnt (perf_instr_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule

`default_nettype wire
